serial_receiver: RTL
====================

SERIAL_RECEIVER -- requirements
Module: serial_receiver

Interface
REQ-001 Parameter SYNC_WORD, default 4'b1011, is the frame sync nibble searched for in the serial stream.
REQ-002 Port CLK  input  1  is the single clock; all state updates occur on its rising edge.
REQ-003 Port RESET  input  1  is the asynchronous, active-high reset.
REQ-004 Port ENB  input  1  is the bit-valid qualifier; S_IN is sampled only on rising edges where ENB=1.
REQ-005 Port S_IN  input  1  is the serial bit stream from the upstream shift register's serial output.
REQ-006 Port DIR  input  1  sets data bit order: 1 = first data bit to Q[3] (MSB first), 0 = first data bit to Q[0] (LSB first).
REQ-007 Port Q  output  4  holds the last good data nibble.
REQ-008 Port VALID  output  1  pulses high for one cycle when Q is updated with a good nibble.
REQ-009 Port ERR  output  1  pulses high for one cycle on a parity failure.
REQ-010 Port LOCKED  output  1  is high while the FSM is in DATA or PARITY.
REQ-011 Port ERR_CNT  output  4  counts parity failures.

Function
REQ-012 Frame format SHALL be: SYNC_WORD (4 bits, MSB first), 4 data bits, 1 even-parity bit; total 9 qualified bits.
REQ-013 FSM states SHALL be HUNT, DATA and PARITY.
REQ-014 HUNT: each qualified bit shifts into a 4-bit window (window <= {window[2:0], S_IN}).
REQ-015 HUNT: when {window[2:0], S_IN} equals SYNC_WORD, the FSM SHALL enter DATA, clear the bit counter and latch DIR for the frame.
REQ-016 Sync match SHALL be sliding, with no bit alignment required; overlapping prefixes SHALL be detected (1,0,1,0,1,1 matches on the 6th bit).
REQ-017 DATA: each qualified bit SHALL be placed per the latched DIR (DIR=1 shifts left into LSB; DIR=0 shifts right into MSB).
REQ-018 DATA: after the 4th data bit, the FSM SHALL enter PARITY; a 2-bit counter tracks the data bits.
REQ-019 DIR changes after sync SHALL NOT affect the frame in progress.
REQ-020 PARITY: on the qualified parity bit, if XOR(data, S_IN)=0 then Q <= data and VALID=1 on that same edge.
REQ-021 PARITY: otherwise ERR=1, Q SHALL be unchanged, and ERR_CNT SHALL increment, saturating at 4'hF.
REQ-022 After PARITY, the FSM SHALL return to HUNT with the window cleared to 4'b0000, so every frame needs its own sync.
REQ-023 ENB=0 SHALL freeze the FSM, window, counter and data; VALID and ERR SHALL be 0 on those cycles.
REQ-024 VALID and ERR SHALL never be high in the same cycle and SHALL each last exactly one cycle.

Reset
REQ-025 RESET=1 SHALL asynchronously force: state=HUNT, window=0, counter=0, Q=4'b0000, VALID=0, ERR=0, ERR_CNT=0, LOCKED=0.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; the first frame after release SHALL require a full sync.
REQ-027 Outputs SHALL hold their reset values until the first qualified edge after RESET deasserts.

Structure
REQ-028 A shared package SHALL hold the state encoding (HUNT=2'b00, DATA=2'b01, PARITY=2'b10), the default SYNC_WORD, the nibble width (4) and the ERR_CNT width (4).
REQ-029 One sub-module, sync_detector, SHALL contain the window register and match compare and output a 1-cycle match strobe; the FSM and data path stay in serial_receiver.

Verification
REQ-030 Good frame: DIR=1, ENB=1, bits 1,0,1,1 | 0,1,1,0 | 0 -> VALID on the 9th edge, Q=4'b0110, ERR_CNT=0.
REQ-031 LSB first: DIR=0, bits 1,0,1,1 | 1,0,0,0 | 1 -> VALID, Q=4'b0001.
REQ-032 Parity error: DIR=1, bits 1,0,1,1 | 1,0,0,0 | 0 -> ERR pulse, Q keeps its prior value, ERR_CNT=1; 16 such frames -> ERR_CNT=4'hF (saturated).
REQ-033 Overlapping sync with ENB gaps: bits 1,0,1,0,1,1 | 0,1,1,0 | 0, with ENB=0 for 3 cycles between data bits -> LOCKED rises after the 6th bit, VALID, Q=4'b0110.
REQ-034 Reset mid-frame: assert RESET after sync plus 2 data bits -> all outputs at reset values immediately; next full good frame -> correct VALID and Q.
REQ-035 DIR toggled during DATA: frame sent with DIR=1 at sync, DIR=0 afterwards -> Q matches the DIR=1 order.

Source files
------------

// File: rtl/serial_receiver_pkg.sv
// Shared types and constants for the serial frame receiver.
// Frame: 4-bit sync word, 4 data bits, 1 even-parity bit.
package serial_receiver_pkg;

    localparam int NIBBLE_W  = 4;
    localparam int ERR_CNT_W = 4;

    localparam logic [NIBBLE_W-1:0] SYNC_WORD_DEFAULT = 4'b1011;

    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        DATA   = 2'b01,
        PARITY = 2'b10
    } state_t;

    // True when data plus parity bit carry an even number of ones.
    function automatic logic even_parity_ok(input logic [NIBBLE_W-1:0] d, input logic p);
        return ~(^d ^ p);
    endfunction

endpackage

// File: rtl/serial_receiver_sync_detector.sv
// Sliding sync-word search window; match is a combinational strobe on the matching qualified bit.
// No backpressure: shifts only when the caller qualifies the bit.
module sync_detector
    import serial_receiver_pkg::*;
#(
    parameter logic [NIBBLE_W-1:0] SYNC_WORD = SYNC_WORD_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic shift,
    input  logic clear,
    input  logic s_in,
    output logic match
);

    logic [NIBBLE_W-1:0] window;
    logic [NIBBLE_W-1:0] next_window;

    assign next_window = {window[NIBBLE_W-2:0], s_in};
    assign match       = shift && (next_window == SYNC_WORD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window <= '0;
        end else if (clear) begin
            window <= '0;
        end else if (shift) begin
            window <= next_window;
        end
    end

endmodule

// File: rtl/serial_receiver.sv
// Serial frame receiver: hunts for the sync word, collects 4 data bits, checks even parity.
// VALID/ERR are registered one-cycle pulses after the parity edge; ENB=0 freezes all frame state.
module serial_receiver
    import serial_receiver_pkg::*;
#(
    parameter logic [NIBBLE_W-1:0] SYNC_WORD = SYNC_WORD_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 ENB,
    input  logic                 S_IN,
    input  logic                 DIR,
    output logic [NIBBLE_W-1:0]  Q,
    output logic                 VALID,
    output logic                 ERR,
    output logic                 LOCKED,
    output logic [ERR_CNT_W-1:0] ERR_CNT
);

    state_t              state;
    state_t              next_state;
    logic [1:0]          cnt;
    logic [NIBBLE_W-1:0] data;
    logic                dir_lat;
    logic                hunt_shift;
    logic                parity_edge;
    logic                sync_match;

    assign hunt_shift  = ENB && (state == HUNT);
    assign parity_edge = ENB && (state == PARITY);
    assign LOCKED      = (state == DATA) || (state == PARITY);

    // Window is cleared at the end of every frame so each frame needs its own sync.
    sync_detector #(.SYNC_WORD(SYNC_WORD)) u_sync (
        .clk   (CLK),
        .rst   (RESET),
        .shift (hunt_shift),
        .clear (parity_edge),
        .s_in  (S_IN),
        .match (sync_match)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= HUNT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            HUNT:    if (sync_match)              next_state = DATA;
            DATA:    if (ENB && (cnt == 2'd3))    next_state = PARITY;
            PARITY:  if (ENB)                     next_state = HUNT;
            default:                              next_state = HUNT;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt     <= 2'd0;
            data    <= '0;
            dir_lat <= 1'b0;
            Q       <= '0;
            VALID   <= 1'b0;
            ERR     <= 1'b0;
            ERR_CNT <= '0;
        end else begin
            VALID <= 1'b0;
            ERR   <= 1'b0;
            if (ENB) begin
                case (state)
                    HUNT: begin
                        if (sync_match) begin
                            cnt     <= 2'd0;
                            dir_lat <= DIR;
                        end
                    end
                    DATA: begin
                        // Bit order is fixed by the DIR captured at sync time.
                        if (dir_lat) begin
                            data <= {data[NIBBLE_W-2:0], S_IN};
                        end else begin
                            data <= {S_IN, data[NIBBLE_W-1:1]};
                        end
                        cnt <= cnt + 2'd1;
                    end
                    PARITY: begin
                        if (even_parity_ok(data, S_IN)) begin
                            Q     <= data;
                            VALID <= 1'b1;
                        end else begin
                            ERR <= 1'b1;
                            if (ERR_CNT != '1) begin
                                ERR_CNT <= ERR_CNT + 1'b1;
                            end
                        end
                    end
                    default: begin
                        cnt <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule
